// File: rtl/lu_pipe.sv
// Two-stage pipelined logic / bit-manipulation unit with valid/ready on both sides.
// Stage 1 holds operands plus the decoded bit mask; stage 2 holds the result and zero flag.
module lu_pipe #(
    parameter  int W  = 16,
    localparam int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [CW-1:0] c,
    input  logic [3:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          zf
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] m;
    } s1_t;

    logic          v1, v2, adv2, accept;
    logic          sel_onehot;
    logic [W-1:0]  m_d;
    s1_t           s1_q;
    logic [W-1:0]  y_d;
    logic          zf_d;
    logic [W-1:0]  bit_c;
    logic [CW-1:0] ffs_idx;
    logic [CW:0]   pop;

    // Ops 5-7 want a one-hot mask at c; op 4 (and TEST) want bits 0..c.
    assign sel_onehot = op[1] | op[0];

    for (genvar i = 0; i < W; i++) begin : g_mask
        assign m_d[i] = sel_onehot ? (c == CW'(i)) : (CW'(i) <= c);
    end

    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept ? 1'b1 : (adv2 ? 1'b0 : v1);
            v2 <= adv2 ? 1'b1 : (out_ready ? 1'b0 : v2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (accept) begin
            s1_q <= '{a: a, b: b, op: op, m: m_d};
        end
    end

    // The range mask 0..c minus its own shift isolates bit c for TEST.
    assign bit_c = s1_q.m & ~(s1_q.m >> 1);

    always_comb begin
        ffs_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (s1_q.a[i]) ffs_idx = i[CW-1:0];
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + {{CW{1'b0}}, s1_q.a[i]};
        end
    end

    always_comb begin
        y_d = '0;
        case (s1_q.op)
            4'd0:    y_d = ~s1_q.b;
            4'd1:    y_d = s1_q.a & s1_q.b;
            4'd2:    y_d = s1_q.a | s1_q.b;
            4'd3:    y_d = s1_q.a ^ s1_q.b;
            4'd4:    y_d = s1_q.a & s1_q.m;
            4'd5:    y_d = s1_q.a | s1_q.m;
            4'd6:    y_d = s1_q.a & ~s1_q.m;
            4'd7:    y_d = s1_q.a ^ s1_q.m;
            4'd8:    y_d = {{(W-1){1'b0}}, |(s1_q.a & bit_c)};
            4'd9:    y_d = {{(W-CW){1'b0}}, ffs_idx};
            4'd10:   y_d = {{(W-CW-1){1'b0}}, pop};
            default: y_d = '0;
        endcase
        zf_d = (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y  <= '0;
            zf <= 1'b0;
        end else if (adv2) begin
            y  <= y_d;
            zf <= zf_d;
        end
    end

endmodule

// File: doc/lu_pipe.md
# lu_pipe

Parametrised, pipelined logic unit: W-bit successor of the 16-bit combinational logic unit. It keeps the eight logic and bit-manipulation operations and adds bit test, find-first-set and population count. It adds a zero flag and a two-stage registered pipeline with valid/ready handshakes on both sides. It sits between the operand-fetch stage and the result write-back mux of the datapath, and tolerates write-back stalls without losing or duplicating results.

## Interface
- W, 16, operand/result width; power of two, 4..64. Derived constant CW = log2(W) sets the bit-select width.
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit accepts this cycle (combinational from state and out_ready)
- a  in  W  first operand
- b  in  W  second operand
- c  in  CW  bit select
- op  in  4  operation code
- out_valid  out  1  y/zf hold a result
- out_ready  in  1  consumer takes result this cycle
- y  out  W  result
- zf  out  1  1 when y == 0

## Operation
- Operation codes (mask bit i of the mask M):
  - 0 NOT B: y = ~b.
  - 1 AND: y = a & b.
  - 2 OR: y = a | b.
  - 3 XOR: y = a ^ b.
  - 4 SELECT: y = a & M, where M[i] = (i <= c).
  - 5 SET: y = a | M.
  - 6 RESET: y = a & ~M.
  - 7 INVERT: y = a ^ M. For ops 5-7, M is one-hot at bit c.
  - 8 TEST: y = {W-1 zeros, a[c]}.
  - 9 FFS: y = index of lowest set bit of a, zero-extended. When a == 0, y = 0. zf reports only y == 0, so FFS of a == 0 and FFS of a == 1 both give zf = 1.
  - 10 POPCOUNT: y = number of ones in a, zero-extended (range 0..W).
  - 11-15 reserved: y = 0, zf = 1.
- b is ignored for ops 4-15. c is ignored for ops 0-3, 9 and 10.
- Stage 1 register (v1): captures a, b, op and the decoded mask M. The mask decoder's multi-bit/one-hot select is driven by op[1]|op[0].
- Stage 2 register (v2): captures y and zf computed from the stage-1 contents. out_valid = v2.
- Control equations:
  - adv2 = v1 & (~v2 | out_ready)
  - in_ready = ~v1 | adv2
  - accept = in_valid & in_ready
  - v1 next = accept ? 1 : (adv2 ? 0 : v1)
  - v2 next = adv2 ? 1 : (out_ready ? 0 : v2)
- Stage data registers load only on accept (stage 1) or adv2 (stage 2). Otherwise they hold.
- While out_valid = 1 and out_ready = 0, y and zf are stable.
- in_valid = 0 with in_ready = 1: no state change in stage 1, and any held data is not reused.

## Timing
- Reset (asynchronous assert, synchronous-release-safe):
  - v1 = v2 = 0, out_valid = 0, y = 0, zf = 0.
  - in_ready = 1 from the first cycle after reset.
- Latency: an operand accepted at edge N appears on y/out_valid after edge N+1, when out_ready was held 1.
- Throughput: one result per clock with out_ready = 1 continuously.
- Full: with v1 = v2 = 1 and out_ready = 0, in_ready = 0. Capacity is exactly two in-flight operations.
- Simultaneous events:
  - With the pipe full, out_ready = 1 and in_valid = 1: both stages shift and a new operand is accepted in the same cycle. No bubble.
  - Stage 1 empty while stage 2 drains: v2 goes to 0 on the next edge.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronously). Nothing is replayed after release.
- Arithmetic and width rules:
  - POPCOUNT needs CW+1 bits. All upper bits of y are 0.
  - c values are always in range, since c has CW bits.

## Test plan
- Logic ops, W=16, out_ready = 1: a=0xF0F0, b=0x3C3C, ops 0-3, back-to-back. Required: y = 0xC3C3, 0x3030, 0xFCFC, 0xCCCC on consecutive cycles, each 2 edges after its accept. zf = 0 for all.
- Bit ops: a=0x00FF, c=10 with ops 4/5/6/7/8. Required: y = 0x00FF, 0x04FF, 0x00FF, 0x04FF, 0x0000 (zf = 1 on op 8). Then c=3, op 6: required y = 0x00F7.
- New ops:
  - FFS, a=0x0040: y = 6.
  - FFS, a=0: y = 0, zf = 1.
  - POPCOUNT, a=0xFFFF: y = 16.
  - op 13: y = 0, zf = 1.
- Backpressure: stream 5 operations with out_ready = 0 for 4 cycles.
  - Required: in_ready falls after two accepts, y holds the first result stable.
  - After out_ready rises, all 5 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n = 0 with v1 = v2 = 1.
  - Required: out_valid = 0, y = 0 immediately.
  - After release, in_ready = 1 and no stale result appears.
- Parameter sweep: W=4 and W=64.
  - POPCOUNT all-ones: required 4 and 64.
  - SET with c = W-1: required top bit set.
  - SELECT with c = W-1: required y = a.
